// File: rtl/fsm_111_detector.sv
// Serial "111" run detector with selectable Moore/Mealy output
// and overlapping or non-overlapping match counting.
module fsm_111_detector #(
  parameter int OVERLAP = 1,
  parameter int MEALY   = 0
) (
  output logic m1,
  input  logic x,
  input  logic clk,
  input  logic reset
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  localparam bit LP_OVL   = (OVERLAP != 0);
  localparam bit LP_MEALY = (MEALY != 0);

  state_t r_state;
  state_t w_next;
  logic   r_m1;
  logic   w_hit;

  always_comb begin
    w_next = S0;
    case (r_state)
      S0: w_next = x ? S1 : S0;
      S1: w_next = x ? S2 : S0;
      S2: begin
        if (!x)
          w_next = S0;
        else if (!LP_MEALY)
          w_next = S3;
        else
          w_next = LP_OVL ? S2 : S0;
      end
      // S3 only exists in the Moore machine
      S3: begin
        if (!x || LP_MEALY)
          w_next = S0;
        else
          w_next = LP_OVL ? S3 : S1;
      end
      default: w_next = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S0;
      r_m1    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_m1    <= !LP_MEALY && (w_next == S3);
    end
  end

  assign w_hit = (r_state == S2) & x & ~reset;
  assign m1    = LP_MEALY ? w_hit : r_m1;

endmodule

// File: tb/tb_fsm_111_detector.sv
// Scoreboard bench for all four fsm_111_detector variants
// against a run-length reference model.
module tb_fsm_111_detector;

  logic clk;
  logic reset;
  logic x;
  logic m_mo;
  logic m_mn;
  logic m_yo;
  logic m_yn;

  fsm_111_detector #(.OVERLAP(1), .MEALY(0)) u_mo (
    .m1(m_mo), .x(x), .clk(clk), .reset(reset)
  );
  fsm_111_detector #(.OVERLAP(0), .MEALY(0)) u_mn (
    .m1(m_mn), .x(x), .clk(clk), .reset(reset)
  );
  fsm_111_detector #(.OVERLAP(1), .MEALY(1)) u_yo (
    .m1(m_yo), .x(x), .clk(clk), .reset(reset)
  );
  fsm_111_detector #(.OVERLAP(0), .MEALY(1)) u_yn (
    .m1(m_yn), .x(x), .clk(clk), .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit0 overlap, bit1 non-overlap
  logic [1:0] q_moore[$];
  logic [1:0] q_mealy[$];

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  // directed prefix: {reset, x}
  localparam int ND = 34;
  logic [1:0] dir_tab [ND] = '{
    2'b11, 2'b11,
    2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
    2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
    2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00,
    2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00,
    2'b01, 2'b01, 2'b01, 2'b01, 2'b00
  };

  // ones seen in a row since the last zero or reset
  int run;

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b",
               nm, $time, act, exp);
    end
  endtask

  initial begin
    logic [1:0] e;
    logic [1:0] sv;
    int r1;
    reset = 1'b1;
    x     = 1'b1;
    run   = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      if (reset)  run = 0;
      else if (x) run = run + 1;
      else        run = 0;
      e[0] = (run >= 3);
      e[1] = (run > 0) && (run % 3 == 0);
      q_moore.push_back(e);
      #1;
      if (c < ND) begin
        sv = dir_tab[c];
        reset = sv[1];
        x     = sv[0];
      end else begin
        reset = ($urandom_range(15) == 0);
        x     = ($urandom_range(3) != 0);
      end
      r1   = run + 1;
      e[0] = x && !reset && (run >= 2);
      e[1] = x && !reset && (r1 % 3 == 0);
      q_mealy.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
  end

  initial begin
    logic [1:0] e;
    while (!done) begin
      @(negedge clk);
      if (q_moore.size() > 0) begin
        e = q_moore.pop_front();
        chk("moore_ovl", m_mo, e[0]);
        chk("moore_nov", m_mn, e[1]);
      end
      if (q_mealy.size() > 0) begin
        e = q_mealy.pop_front();
        chk("mealy_ovl", m_yo, e[0]);
        chk("mealy_nov", m_yn, e[1]);
      end
    end
    checks++;
    if (checks < 2000) begin
      errors++;
      $display("FAIL check_count got=%0d want>=2000", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
